dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameters SHALL be ADDR_W (default 15, word-address width), DATA_W (default 32, data width) and STARVE_MAX (default 4, max consecutive ext denials).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 cpu_req, cpu_we  input  1 each  CPU MEM-stage access request and write qualifier.
REQ-005 cpu_addr  input  ADDR_W  CPU word address; cpu_wdata  input  DATA_W  CPU store data.
REQ-006 cpu_gnt  output  1  CPU command issued this cycle; cpu_stall  output  1  equals cpu_req AND NOT cpu_gnt.
REQ-007 cpu_rvalid  output  1  CPU read data valid; cpu_rdata  output  DATA_W  CPU read data.
REQ-008 ext_req, ext_we, ext_lock  input  1 each  external (loader/DMA) request, write qualifier and burst lock.
REQ-009 ext_addr  input  ADDR_W, ext_wdata  input  DATA_W; ext_gnt, ext_rvalid  output  1 each; ext_rdata  output  DATA_W.
REQ-010 mem_re, mem_we  output  1 each; mem_addr  output  ADDR_W; mem_wdata  output  DATA_W; mem_rdata  input  DATA_W (synchronous memory, data one cycle after mem_re).

Function
REQ-011 At most one of cpu_gnt and ext_gnt SHALL be high in any cycle; a grant is combinational from the current request, state and starvation count.
REQ-012 A requester SHALL hold req, we, addr and wdata stable until its gnt is high; the command is accepted in the grant cycle.
REQ-013 In the grant cycle, mem_re = NOT we, mem_we = we, and mem_addr/mem_wdata are taken from the granted port; with no grant, mem_re = mem_we = 0.
REQ-014 Back-to-back grants SHALL be allowed every cycle, giving one command per cycle of throughput.
REQ-015 A granted read SHALL assert that port's rvalid exactly one cycle later, with rdata = mem_rdata; the owner is tracked in a registered rd_owner field (NONE/CPU/EXT).
REQ-016 rdata of the non-owning port SHALL hold its last value; rvalid of the non-owning port SHALL be 0.
REQ-017 The FSM states SHALL be IDLE, CPU_OWN, EXT_OWN and EXT_LOCK, each recording the last granted port.
REQ-018 Fixed-priority mode: the CPU wins a simultaneous request unless starve_cnt == STARVE_MAX, in which case ext wins.
REQ-019 starve_cnt SHALL increment while ext_req is denied, clear on ext_gnt, and saturate at STARVE_MAX.
REQ-020 IDLE/CPU_OWN/EXT_OWN -> EXT_LOCK when ext is granted with ext_lock=1; in EXT_LOCK only ext is granted; EXT_LOCK -> EXT_OWN when ext_lock=0.
REQ-021 A write granted in the same cycle a read returns SHALL not disturb the returning rvalid/rdata.
REQ-022 With no request, the FSM SHALL remain in its current state and rd_owner SHALL go to NONE.

Reset
REQ-023 While rst_n=0, the state SHALL be IDLE, rd_owner NONE, starve_cnt 0, and all gnt, rvalid, mem_re and mem_we SHALL be 0.
REQ-024 While rst_n=0, rdata outputs SHALL be 0; a read in flight at reset SHALL be discarded (no rvalid after release).

Configuration
REQ-025 With macro DMEM_ARB_RR_EN defined, a simultaneous request (outside EXT_LOCK) SHALL be granted to the port not granted last (round-robin), and starve_cnt logic is removed.
REQ-026 Without DMEM_ARB_RR_EN, the fixed-priority and starvation behaviour of REQ-018/019 applies.

Structure
REQ-027 Package dmem_arb_pkg SHALL hold the state enum, the rd_owner enum, and the ADDR_W/DATA_W defaults.
REQ-028 One sub-module, dmem_arb_starve_ctr (saturating counter), SHALL be instantiated only when DMEM_ARB_RR_EN is undefined.

Verification
REQ-029 CPU read only: cpu_req=1, we=0, addr=0x0010, mem returns 0xDEADBEEF -> cpu_gnt in cycle 0; cpu_rvalid=1 with 0xDEADBEEF in cycle 1; ext_rvalid=0.
REQ-030 Both ports request continuously, fixed priority, STARVE_MAX=4 -> 4 CPU grants, then 1 ext grant, repeating; cpu_stall=1 in the ext cycle.
REQ-031 ext_lock=1 for 6 ext writes while cpu_req=1 -> 6 consecutive ext_gnt and cpu_stall=1 throughout; CPU granted the cycle after ext_lock falls.
REQ-032 DMEM_ARB_RR_EN defined, both ports request -> grants alternate CPU/ext every cycle, starting with CPU from IDLE.
REQ-033 CPU read granted, rst_n pulsed low the next cycle -> no cpu_rvalid, all outputs 0, state IDLE.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg
//   Shared types and defaults for the data-memory arbiter.
//   - arb_state_e : arbiter FSM state, records the last granted port
//   - rd_owner_e  : which port owns the read returning next cycle
//   - ADDR_W_DEF / DATA_W_DEF : default word-address and data widths
package dmem_arb_pkg;

   localparam int unsigned ADDR_W_DEF = 15;
   localparam int unsigned DATA_W_DEF = 32;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_CPU_OWN  = 2'd1,
      ST_EXT_OWN  = 2'd2,
      ST_EXT_LOCK = 2'd3
   } arb_state_e;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_CPU  = 2'd1,
      OWN_EXT  = 2'd2
   } rd_owner_e;

endpackage

// File: rtl/dmem_arb_starve_ctr.sv
// dmem_arb_starve_ctr
//   Saturating count of consecutive external-port denials.
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset
//     inc        : ext requested but was denied this cycle
//     clr        : ext granted this cycle (takes precedence over inc)
//     at_max     : count has reached MAX
module dmem_arb_starve_ctr
   import dmem_arb_pkg::*;
#(
   parameter int unsigned MAX = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic inc,
   input  logic clr,
   output logic at_max
);

   localparam int unsigned   CW    = $clog2(MAX + 1);
   localparam logic [CW-1:0] MAX_V = CW'(MAX);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc && (cnt_q != MAX_V)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign at_max = (cnt_q == MAX_V);

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Two-port arbiter (CPU MEM stage vs. external loader/DMA) in front of a
//   single-port synchronous data memory. One command per cycle; a read
//   returns on the granted port one cycle later.
//   Ports:
//     clk, rst_n                         : clock, asynchronous active-low reset
//     cpu_req/we/addr/wdata              : CPU command, held until cpu_gnt
//     cpu_gnt, cpu_stall                 : CPU issue / stall
//     cpu_rvalid, cpu_rdata              : CPU read return
//     ext_req/we/lock/addr/wdata         : external command, lock holds the bus
//     ext_gnt, ext_rvalid, ext_rdata     : external grant / read return
//     mem_re/we/addr/wdata, mem_rdata    : memory port (rdata one cycle after re)
//   Configuration macro DMEM_ARB_RR_EN: round-robin on simultaneous requests
//   instead of CPU priority with starvation guard.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W     = ADDR_W_DEF,
   parameter int unsigned DATA_W     = DATA_W_DEF,
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_gnt,
   output logic              cpu_stall,
   output logic              cpu_rvalid,
   output logic [DATA_W-1:0] cpu_rdata,
   input  logic              ext_req,
   input  logic              ext_we,
   input  logic              ext_lock,
   input  logic [ADDR_W-1:0] ext_addr,
   input  logic [DATA_W-1:0] ext_wdata,
   output logic              ext_gnt,
   output logic              ext_rvalid,
   output logic [DATA_W-1:0] ext_rdata,
   output logic              mem_re,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   arb_state_e        state_q, state_d;
   rd_owner_e         rd_owner_q, rd_owner_d;
   logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
   logic [DATA_W-1:0] ext_rdata_q, ext_rdata_d;
   logic              cpu_win, ext_win;
   logic              ext_wins_tie;

`ifdef DMEM_ARB_RR_EN
   // Ext takes a tie only if the CPU had the previous grant; IDLE and
   // EXT_OWN both favour the CPU, so arbitration starts with the CPU.
   assign ext_wins_tie = (state_q == ST_CPU_OWN);
`else
   dmem_arb_starve_ctr #(
      .MAX (STARVE_MAX)
   ) u_starve_ctr (
      .clk    (clk),
      .rst_n  (rst_n),
      .inc    (ext_req & ~ext_win),
      .clr    (ext_win),
      .at_max (ext_wins_tie)
   );
`endif

   // Arbitration is kept ungated for the state logic (flops are held in
   // reset anyway); rst_n only masks the externally visible strobes so
   // the async reset net never reaches a flop D input.
   always_comb begin
      cpu_win = 1'b0;
      ext_win = 1'b0;
      if (state_q == ST_EXT_LOCK) begin
         ext_win = ext_req;
      end else if (cpu_req && ext_req) begin
         ext_win = ext_wins_tie;
         cpu_win = ~ext_wins_tie;
      end else begin
         cpu_win = cpu_req;
         ext_win = ext_req;
      end
   end

   always_comb begin
      cpu_gnt   = cpu_win & rst_n;
      ext_gnt   = ext_win & rst_n;
      cpu_stall = cpu_req & ~cpu_gnt;
      mem_re    = (cpu_gnt & ~cpu_we) | (ext_gnt & ~ext_we);
      mem_we    = (cpu_gnt & cpu_we) | (ext_gnt & ext_we);
      mem_addr  = '0;
      mem_wdata = '0;
      if (cpu_gnt) begin
         mem_addr  = cpu_addr;
         mem_wdata = cpu_wdata;
      end else if (ext_gnt) begin
         mem_addr  = ext_addr;
         mem_wdata = ext_wdata;
      end
   end

   always_comb begin
      state_d = state_q;
      if (ext_win) begin
         state_d = ext_lock ? ST_EXT_LOCK : ST_EXT_OWN;
      end else if (cpu_win) begin
         state_d = ST_CPU_OWN;
      end else if ((state_q == ST_EXT_LOCK) && !ext_lock) begin
         state_d = ST_EXT_OWN;
      end
   end

   always_comb begin
      rd_owner_d = OWN_NONE;
      if (cpu_win && !cpu_we) begin
         rd_owner_d = OWN_CPU;
      end else if (ext_win && !ext_we) begin
         rd_owner_d = OWN_EXT;
      end
   end

   // Each port's rdata shows memory data in its return cycle and holds it
   // afterwards, so a write issued in that cycle cannot disturb it.
   always_comb begin
      cpu_rdata_d = cpu_rdata_q;
      ext_rdata_d = ext_rdata_q;
      if (rd_owner_q == OWN_CPU) begin
         cpu_rdata_d = mem_rdata;
      end
      if (rd_owner_q == OWN_EXT) begin
         ext_rdata_d = mem_rdata;
      end
      cpu_rvalid = (rd_owner_q == OWN_CPU);
      ext_rvalid = (rd_owner_q == OWN_EXT);
      cpu_rdata  = cpu_rdata_d;
      ext_rdata  = ext_rdata_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         rd_owner_q  <= OWN_NONE;
         cpu_rdata_q <= '0;
         ext_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         rd_owner_q  <= rd_owner_d;
         cpu_rdata_q <= cpu_rdata_d;
         ext_rdata_q <= ext_rdata_d;
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
//   Directed bench for dmem_arbiter with a behavioural reference model and
//   a synchronous memory model driving mem_rdata.
module tb_dmem_arbiter;

   localparam int unsigned ADDR_W     = 15;
   localparam int unsigned DATA_W     = 32;
   localparam int unsigned STARVE_MAX = 4;

   logic              clk = 1'b0;
   logic              rst_n = 1'b1;
   logic              cpu_req = 1'b0, cpu_we = 1'b0;
   logic [ADDR_W-1:0] cpu_addr = '0;
   logic [DATA_W-1:0] cpu_wdata = '0;
   logic              cpu_gnt, cpu_stall, cpu_rvalid;
   logic [DATA_W-1:0] cpu_rdata;
   logic              ext_req = 1'b0, ext_we = 1'b0, ext_lock = 1'b0;
   logic [ADDR_W-1:0] ext_addr = '0;
   logic [DATA_W-1:0] ext_wdata = '0;
   logic              ext_gnt, ext_rvalid;
   logic [DATA_W-1:0] ext_rdata;
   logic              mem_re, mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata = '0;

   int checks = 0;
   int errors = 0;

   dmem_arbiter #(
      .ADDR_W     (ADDR_W),
      .DATA_W     (DATA_W),
      .STARVE_MAX (STARVE_MAX)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cpu_req    (cpu_req),
      .cpu_we     (cpu_we),
      .cpu_addr   (cpu_addr),
      .cpu_wdata  (cpu_wdata),
      .cpu_gnt    (cpu_gnt),
      .cpu_stall  (cpu_stall),
      .cpu_rvalid (cpu_rvalid),
      .cpu_rdata  (cpu_rdata),
      .ext_req    (ext_req),
      .ext_we     (ext_we),
      .ext_lock   (ext_lock),
      .ext_addr   (ext_addr),
      .ext_wdata  (ext_wdata),
      .ext_gnt    (ext_gnt),
      .ext_rvalid (ext_rvalid),
      .ext_rdata  (ext_rdata),
      .mem_re     (mem_re),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Memory seen by the DUT, and the model's own copy of the same contents.
   logic [DATA_W-1:0] mem_arr   [256];
   logic [DATA_W-1:0] model_mem [256];

   initial begin
      for (int i = 0; i < 256; i++) begin
         mem_arr[i]   = 32'hA500_0000 + 32'(i) * 32'h0001_0101;
         model_mem[i] = 32'hA500_0000 + 32'(i) * 32'h0001_0101;
      end
      mem_arr[8'h10]   = 32'hDEADBEEF;
      model_mem[8'h10] = 32'hDEADBEEF;
   end

   always @(posedge clk) begin
      if (mem_we) mem_arr[mem_addr[7:0]] <= mem_wdata;
      if (mem_re) mem_rdata <= mem_arr[mem_addr[7:0]];
   end

   // Reference model: last-granted port (0 none, 1 cpu, 2 ext), lock flag,
   // denial count, and the read due back next cycle (0 none, 1 cpu, 2 ext).
   int          m_last = 0;
   bit          m_locked = 1'b0;
   int          m_starve = 0;
   int          m_pend = 0;
   logic [31:0] m_pdata = '0, m_cpu_hold = '0, m_ext_hold = '0;

   initial begin
      bit cg, eg;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            cg = 1'b0; eg = 1'b0;
         end else if (m_locked) begin
            cg = 1'b0; eg = ext_req;
         end else if (cpu_req && ext_req) begin
`ifdef DMEM_ARB_RR_EN
            eg = (m_last == 1);
`else
            eg = (m_starve == int'(STARVE_MAX));
`endif
            cg = !eg;
         end else begin
            cg = cpu_req; eg = ext_req;
         end
         chk("cpu_gnt",   cpu_gnt,   cg);
         chk("ext_gnt",   ext_gnt,   eg);
         chk("cpu_stall", cpu_stall, cpu_req && !cg);
         chk("mem_re",    mem_re,    (cg && !cpu_we) || (eg && !ext_we));
         chk("mem_we",    mem_we,    (cg && cpu_we) || (eg && ext_we));
         if (cg) begin
            chk("mem_addr_cpu", mem_addr, cpu_addr);
            if (cpu_we) chk("mem_wdata_cpu", mem_wdata, cpu_wdata);
         end
         if (eg) begin
            chk("mem_addr_ext", mem_addr, ext_addr);
            if (ext_we) chk("mem_wdata_ext", mem_wdata, ext_wdata);
         end
         chk("cpu_rvalid", cpu_rvalid, rst_n && (m_pend == 1));
         chk("ext_rvalid", ext_rvalid, rst_n && (m_pend == 2));
         chk("cpu_rdata", cpu_rdata, !rst_n ? 32'h0 : ((m_pend == 1) ? m_pdata : m_cpu_hold));
         chk("ext_rdata", ext_rdata, !rst_n ? 32'h0 : ((m_pend == 2) ? m_pdata : m_ext_hold));

         @(posedge clk);
         if (!rst_n) begin
            m_last = 0; m_locked = 1'b0; m_starve = 0; m_pend = 0;
            m_pdata = '0; m_cpu_hold = '0; m_ext_hold = '0;
         end else begin
            if (m_pend == 1) m_cpu_hold = m_pdata;
            if (m_pend == 2) m_ext_hold = m_pdata;
            m_pend = 0;
            if (cg) begin
               m_last = 1;
               if (cpu_we) model_mem[cpu_addr[7:0]] = cpu_wdata;
               else begin m_pend = 1; m_pdata = model_mem[cpu_addr[7:0]]; end
            end
            if (eg) begin
               m_last = 2;
               if (ext_we) model_mem[ext_addr[7:0]] = ext_wdata;
               else begin m_pend = 2; m_pdata = model_mem[ext_addr[7:0]]; end
            end
            if (eg) m_locked = ext_lock;
            else if (!ext_lock) m_locked = 1'b0;
            if (eg) m_starve = 0;
            else if (ext_req && m_starve < int'(STARVE_MAX)) m_starve++;
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [9:0] mask;
      logic [9:0] exp_mask;
      int ng, ns;
`ifdef DMEM_ARB_RR_EN
      exp_mask = 10'b10_1010_1010;
`else
      exp_mask = 10'b10_0001_0000;
`endif
      #2 rst_n = 1'b0;
      tick(); tick();
      @(negedge clk);
      chk("reset_strobes", {cpu_gnt, ext_gnt, cpu_rvalid, ext_rvalid, mem_re, mem_we}, 6'b0);
      chk("reset_rdata", {cpu_rdata, ext_rdata}, 64'h0);
      tick(); rst_n = 1'b1;
      @(negedge clk); tick();

      // CPU read of 0x10
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h0010;
      @(negedge clk); chk("rd_gnt_c0", cpu_gnt, 1'b1);
      tick(); cpu_req = 1'b0;
      @(negedge clk);
      chk("rd_rvalid_c1", cpu_rvalid, 1'b1);
      chk("rd_rdata_c1", cpu_rdata, 32'hDEADBEEF);
      chk("rd_ext_rvalid_c1", ext_rvalid, 1'b0);
      tick();
      @(negedge clk);
      chk("rd_hold", {cpu_rvalid, cpu_rdata}, {1'b0, 32'hDEADBEEF});
      tick();

      // read, write to same word while the read returns, read back
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h0020;
      @(negedge clk); tick();
      cpu_we = 1'b1; cpu_wdata = 32'h1234_5678;
      @(negedge clk); chk("wr_during_return", {cpu_rvalid, mem_we}, 2'b11); tick();
      cpu_we = 1'b0;
      @(negedge clk); tick();
      cpu_req = 1'b0;
      @(negedge clk); chk("readback", cpu_rdata, 32'h1234_5678); tick();

      // reset pulse with a CPU read in flight
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h0010;
      @(negedge clk); chk("inflight_gnt", cpu_gnt, 1'b1); tick();
      rst_n = 1'b0; cpu_req = 1'b0; cpu_addr = '0;
      @(negedge clk);
      chk("rst_outs", {cpu_gnt, cpu_stall, cpu_rvalid, ext_gnt, ext_rvalid, mem_re, mem_we}, 7'b0);
      chk("rst_data", {cpu_rdata, ext_rdata, 17'(mem_addr)}, 81'h0);
      tick(); rst_n = 1'b1;
      @(negedge clk); chk("post_rst_no_rvalid", {cpu_rvalid, cpu_rdata}, 33'h0); tick();

      // both ports request continuously from IDLE
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h0040;
      ext_req = 1'b1; ext_we = 1'b0; ext_addr = 15'h0030;
      mask = '0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         mask[i] = ext_gnt;
         if (ext_gnt) chk("both_stall_on_ext", cpu_stall, 1'b1);
         tick();
      end
      chk("both_pattern", mask, exp_mask);
      cpu_req = 1'b0; ext_req = 1'b0;
      @(negedge clk); tick();

      // locked ext write burst
      ext_req = 1'b1; ext_we = 1'b1; ext_lock = 1'b1;
      ext_addr = 15'h0050; ext_wdata = 32'hE000_0000;
      cpu_addr = 15'h0060; cpu_we = 1'b0;
      ng = 0; ns = 0;
      for (int i = 0; i < 6; i++) begin
         if (i == 1) cpu_req = 1'b1;
         @(negedge clk);
         ng += int'(ext_gnt);
         if (i > 0) ns += int'(cpu_stall);
         tick();
         ext_addr  = 15'(32'h50 + 32'(i) + 32'd1);
         ext_wdata = 32'hE000_0000 + 32'(i) + 32'd1;
      end
      ext_req = 1'b0; ext_lock = 1'b0; ext_we = 1'b0;
      @(negedge clk);
      chk("lock_release_stall", {cpu_stall, cpu_gnt}, 2'b10);
      tick();
      @(negedge clk); chk("cpu_after_lock", cpu_gnt, 1'b1); tick();
      cpu_req = 1'b0;
      chk("lock_ext_grants", 32'(ng), 32'd6);
      chk("lock_cpu_stalls", 32'(ns), 32'd5);

      // ext read of a word written in the burst
      ext_req = 1'b1; ext_we = 1'b0; ext_addr = 15'h0052;
      @(negedge clk); chk("ext_rd_gnt", ext_gnt, 1'b1); tick();
      ext_req = 1'b0;
      @(negedge clk);
      chk("ext_rd_data", {ext_rvalid, cpu_rvalid, ext_rdata}, {2'b10, 32'hE000_0002});
      tick();
      @(negedge clk); tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
